// File: rtl/uart_rx_param_pkg.sv
// Shared frame-format constants, FSM state encoding and a width helper
// for the parametrised UART receiver.
package uart_rx_param_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BRK    = 3'd5
  } rx_state_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r++;
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_param_fifo.sv
// Synchronous receive FIFO with valid/ready read side; a push into a full
// FIFO with no simultaneous pop is dropped and flagged on overrun.
module uart_rx_param_fifo
  import uart_rx_param_pkg::*;
#(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             valid,
  input  logic             ready,
  output logic             overrun
);

  localparam int AW = clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             empty;
  logic             full;
  logic             pop;
  logic             wr_en;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign valid = !empty;
  assign pop   = valid && ready;
  assign wr_en = push && (!full || pop);
  assign dout  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (res) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      overrun <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      overrun <= push && full && !pop;
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= din;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchronizer, 3-sample majority voter, frame FSM
// with parity/stop checking, feeding a small receive FIFO.
module uart_rx_param
  import uart_rx_param_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 res,
  input  logic                 sample_en,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_perr,
  output logic                 rx_ferr,
  output logic                 rx_valid,
  input  logic                 rx_ready,
  output logic                 overrun,
  output logic                 busy
);

  localparam int TW = clog2(OVERSAMPLE);
  localparam int FW = DATA_BITS + 2;

  localparam logic [TW-1:0] TICK_MAX  = TW'(OVERSAMPLE - 1);
  localparam logic [TW-1:0] TICK_PRE  = TW'(OVERSAMPLE - 2);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  logic                 rx_meta;
  logic                 rxs;
  rx_state_e            state;
  rx_state_e            state_nxt;
  logic [TW-1:0]        tick;
  logic [TW-1:0]        tick_nxt;
  logic [TW-1:0]        tick_inc;
  logic [3:0]           bit_cnt;
  logic [3:0]           bit_cnt_nxt;
  logic [DATA_BITS-1:0] shreg;
  logic [DATA_BITS-1:0] shreg_nxt;
  logic                 par_acc;
  logic                 par_acc_nxt;
  logic                 perr;
  logic                 perr_nxt;
  logic                 ferr;
  logic                 ferr_nxt;
  logic [1:0]           smp;
  logic [1:0]           smp_nxt;
  logic                 centre;
  logic                 vote;
  logic                 push;
  logic [FW-1:0]        push_word;
  logic [FW-1:0]        head;

  // Tick value this sample_en moves to; tick 0 marks the centre of a bit.
  assign tick_inc = (tick == TICK_MAX) ? '0 : tick + 1'b1;
  assign centre   = (tick_inc == '0);
  assign vote     = (smp[0] & smp[1]) | (smp[0] & rxs) | (smp[1] & rxs);
  assign busy     = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (res) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
      state   <= ST_IDLE;
      tick    <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_acc <= 1'b0;
      perr    <= 1'b0;
      ferr    <= 1'b0;
      smp     <= '0;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
      state   <= state_nxt;
      tick    <= tick_nxt;
      bit_cnt <= bit_cnt_nxt;
      shreg   <= shreg_nxt;
      par_acc <= par_acc_nxt;
      perr    <= perr_nxt;
      ferr    <= ferr_nxt;
      smp     <= smp_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    tick_nxt    = tick;
    bit_cnt_nxt = bit_cnt;
    shreg_nxt   = shreg;
    par_acc_nxt = par_acc;
    perr_nxt    = perr;
    ferr_nxt    = ferr;
    smp_nxt     = smp;
    push        = 1'b0;

    if (sample_en) begin
      // The two samples just before each bit centre feed the voter.
      if (tick_inc == TICK_PRE) smp_nxt[0] = rxs;
      if (tick_inc == TICK_MAX) smp_nxt[1] = rxs;

      unique case (state)
        ST_IDLE: begin
          if (!rxs) begin
            state_nxt = ST_START;
            tick_nxt  = '0;
          end
        end

        ST_START: begin
          tick_nxt = tick_inc;
          if (tick_inc == TICK_MID) begin
            if (rxs) begin
              state_nxt = ST_IDLE;
            end else begin
              state_nxt   = ST_DATA;
              tick_nxt    = '0;
              bit_cnt_nxt = '0;
              par_acc_nxt = 1'b0;
              perr_nxt    = 1'b0;
              ferr_nxt    = 1'b0;
            end
          end
        end

        ST_DATA: begin
          tick_nxt = tick_inc;
          if (centre) begin
            shreg_nxt   = {vote, shreg[DATA_BITS-1:1]};
            par_acc_nxt = par_acc ^ vote;
            if (bit_cnt == LAST_DATA) begin
              bit_cnt_nxt = '0;
              state_nxt   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end

        ST_PARITY: begin
          tick_nxt = tick_inc;
          if (centre) begin
            // par_acc ^ vote is the parity of all ones in data plus parity bit.
            perr_nxt  = (PARITY == PAR_ODD) ? ~(par_acc ^ vote) : (par_acc ^ vote);
            state_nxt = ST_STOP;
          end
        end

        ST_STOP: begin
          tick_nxt = tick_inc;
          if (centre) begin
            if (!vote) ferr_nxt = 1'b1;
            if (bit_cnt == LAST_STOP) begin
              push        = 1'b1;
              bit_cnt_nxt = '0;
              state_nxt   = vote ? ST_IDLE : ST_BRK;
            end else begin
              bit_cnt_nxt = bit_cnt + 4'd1;
            end
          end
        end

        ST_BRK: begin
          if (rxs) state_nxt = ST_IDLE;
        end

        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  assign push_word = {shreg, perr, ferr_nxt};

  uart_rx_param_fifo #(
    .WIDTH(FW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk    (clk),
    .res    (res),
    .push   (push),
    .din    (push_word),
    .dout   (head),
    .valid  (rx_valid),
    .ready  (rx_ready),
    .overrun(overrun)
  );

  assign {rx_data, rx_perr, rx_ferr} = head;

endmodule

// File: tb/tb_uart_rx_param.sv
// Scoreboard bench: frames are issued with their expected words queued from a
// frame-level model; monitors pop and compare on every accepted beat.
module tb_uart_rx_param;

  localparam int OS      = 16;
  localparam int SPACING = 4;
  localparam int BIT_CLK = OS * SPACING;
  localparam int DEPTH   = 4;

  logic clk = 1'b0;
  logic res = 1'b1;
  logic sample_en = 1'b0;
  logic rx_a = 1'b1;
  logic rx_b = 1'b1;
  logic fix_rdy_a = 1'b1;
  logic fix_rdy_b = 1'b1;
  logic rnd_rdy_a = 1'b0;
  logic rnd_rdy_b = 1'b0;
  logic rand_mode = 1'b0;
  logic rdy_a, rdy_b;

  logic [7:0] data_a, data_b;
  logic perr_a, ferr_a, valid_a, ovr_a, busy_a;
  logic perr_b, ferr_b, valid_b, ovr_b, busy_b;

  int total = 0;
  int bad = 0;
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  int exp_ovr_a = 0, exp_ovr_b = 0;
  int ovr_cnt_a = 0, ovr_cnt_b = 0;
  int vcnt_a = 0;
  logic pv_a = 1'b0, pr_a = 1'b0, pv_b = 1'b0, pr_b = 1'b0;

  assign rdy_a = rand_mode ? rnd_rdy_a : fix_rdy_a;
  assign rdy_b = rand_mode ? rnd_rdy_b : fix_rdy_b;

  always #5 clk = ~clk;

  uart_rx_param #(
    .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut_a (
    .clk(clk), .res(res), .sample_en(sample_en), .rx(rx_a),
    .rx_data(data_a), .rx_perr(perr_a), .rx_ferr(ferr_a), .rx_valid(valid_a),
    .rx_ready(rdy_a), .overrun(ovr_a), .busy(busy_a)
  );

  uart_rx_param #(
    .OVERSAMPLE(OS), .DATA_BITS(8), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
  ) dut_b (
    .clk(clk), .res(res), .sample_en(sample_en), .rx(rx_b),
    .rx_data(data_b), .rx_perr(perr_b), .rx_ferr(ferr_b), .rx_valid(valid_b),
    .rx_ready(rdy_b), .overrun(ovr_b), .busy(busy_b)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Frame-level reference: parity over data plus parity bit, ferr if any stop bit is low.
  function automatic logic [9:0] model(input logic [7:0] d, input int pmode, input logic pbit,
                                       input logic [1:0] stops, input int nstop);
    int   ones;
    logic pe, fe;
    ones = $countones(d) + int'(pbit);
    if (pmode == 0)      pe = 1'b0;
    else if (pmode == 1) pe = (ones % 2 == 0);
    else                 pe = (ones % 2 == 1);
    fe = (stops[0] == 1'b0) || (nstop == 2 && stops[1] == 1'b0);
    return {d, pe, fe};
  endfunction

  task automatic drive(input int sel, input logic v, input int nclk);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
    repeat (nclk) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input int sel, input logic [7:0] d, input logic pbit,
                            input logic [1:0] stops);
    if (sel == 0) begin
      if (exp_a.size() >= DEPTH) exp_ovr_a++;
      else exp_a.push_back(model(d, 0, pbit, stops, 1));
    end else begin
      if (exp_b.size() >= DEPTH) exp_ovr_b++;
      else exp_b.push_back(model(d, 2, pbit, stops, 2));
    end
    drive(sel, 1'b0, BIT_CLK);
    for (int i = 0; i < 8; i++) drive(sel, d[i], BIT_CLK);
    if (sel == 1) drive(sel, pbit, BIT_CLK);
    drive(sel, stops[0], BIT_CLK);
    if (sel == 1) drive(sel, stops[1], BIT_CLK);
  endtask

  task automatic wait_empty(input int sel);
    int n;
    n = 0;
    while (((sel == 0) ? exp_a.size() : exp_b.size()) != 0 && n < 400) begin
      @(posedge clk);
      n++;
    end
    #1;
    check((sel == 0) ? "drain_a" : "drain_b", (sel == 0) ? exp_a.size() : exp_b.size(), 0);
  endtask

  initial begin
    forever begin
      repeat (SPACING - 1) @(posedge clk);
      #1 sample_en = 1'b1;
      @(posedge clk);
      #1 sample_en = 1'b0;
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      rnd_rdy_a = 1'($urandom_range(0, 1));
      rnd_rdy_b = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (res) begin
        pv_a = 1'b0;
        pv_b = 1'b0;
      end else begin
        if (valid_a) vcnt_a++;
        if (ovr_a) ovr_cnt_a++;
        if (ovr_b) ovr_cnt_b++;
        if (pv_a && !pr_a) check("hold_a", valid_a, 1);
        if (pv_b && !pr_b) check("hold_b", valid_b, 1);
        if (valid_a && rdy_a) begin
          if (exp_a.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_a actual=0x%0h required=none", {data_a, perr_a, ferr_a});
          end else begin
            check("beat_a", {data_a, perr_a, ferr_a}, exp_a.pop_front());
          end
        end
        if (valid_b && rdy_b) begin
          if (exp_b.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_b actual=0x%0h required=none", {data_b, perr_b, ferr_b});
          end else begin
            check("beat_b", {data_b, perr_b, ferr_b}, exp_b.pop_front());
          end
        end
        pv_a = valid_a;
        pr_a = rdy_a;
        pv_b = valid_b;
        pr_b = rdy_b;
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int v0;
    logic [7:0] d;
    logic [1:0] st;
    int sel;

    #1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_data", data_a, 0);
    check("rst_perr", perr_a, 0);
    check("rst_ferr", ferr_a, 0);
    check("rst_valid", valid_a, 0);
    check("rst_overrun", ovr_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_valid_b", valid_b, 0);
    check("rst_busy_b", busy_b, 0);
    res = 1'b0;
    drive(0, 1'b1, BIT_CLK);

    // single frame, consumer always ready
    v0 = vcnt_a;
    send_frame(0, 8'hA5, 1'b0, 2'b11);
    drive(0, 1'b1, BIT_CLK);
    check("t1_valid_cycles", vcnt_a - v0, 1);
    wait_empty(0);

    // even parity: 0x03 has two ones, so parity bit 1 is wrong and 0 is right
    send_frame(1, 8'h03, 1'b1, 2'b11);
    drive(1, 1'b1, BIT_CLK);
    send_frame(1, 8'h03, 1'b0, 2'b11);
    drive(1, 1'b1, BIT_CLK);
    wait_empty(1);

    // low stop bit followed by a held-low line
    send_frame(0, 8'h55, 1'b0, 2'b00);
    drive(0, 1'b0, 3 * BIT_CLK);
    check("t3_busy_brk", busy_a, 1);
    drive(0, 1'b1, BIT_CLK);
    check("t3_idle", busy_a, 0);
    wait_empty(0);

    // 7-tick glitch is rejected as a false start
    v0 = vcnt_a;
    drive(0, 1'b0, 7 * SPACING);
    drive(0, 1'b1, BIT_CLK);
    check("t4_busy", busy_a, 0);
    check("t4_no_entry", vcnt_a - v0, 0);

    // fill the FIFO with the consumer stalled
    fix_rdy_a = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(0, 8'(i), 1'b0, 2'b11);
    drive(0, 1'b1, BIT_CLK);
    check("t5_no_ovr_yet", ovr_cnt_a, 0);
    send_frame(0, 8'h05, 1'b0, 2'b11);
    drive(0, 1'b1, BIT_CLK);
    check("t5_ovr", ovr_cnt_a, exp_ovr_a);
    check("t5_valid", valid_a, 1);
    fix_rdy_a = 1'b1;
    wait_empty(0);

    // reset in the middle of a data bit with two entries queued
    fix_rdy_a = 1'b0;
    send_frame(0, 8'h11, 1'b0, 2'b11);
    send_frame(0, 8'h22, 1'b0, 2'b11);
    drive(0, 1'b1, BIT_CLK);
    check("t6_queued", valid_a, 1);
    drive(0, 1'b0, BIT_CLK);
    drive(0, 1'b1, BIT_CLK);
    drive(0, 1'b0, BIT_CLK / 2);
    check("t6_busy_pre", busy_a, 1);
    res = 1'b1;
    rx_a = 1'b1;
    @(posedge clk);
    #1;
    res = 1'b0;
    exp_a.delete();
    check("t6_valid", valid_a, 0);
    check("t6_busy", busy_a, 0);
    check("t6_data", data_a, 0);
    fix_rdy_a = 1'b1;
    drive(0, 1'b1, BIT_CLK);
    check("t6_no_ovr", ovr_cnt_a, exp_ovr_a);
    send_frame(0, 8'h3C, 1'b0, 2'b11);
    drive(0, 1'b1, BIT_CLK);
    wait_empty(0);

    // randomized frames on both receivers with a random consumer
    rand_mode = 1'b1;
    for (int n = 0; n < 14; n++) begin
      sel = int'($urandom_range(0, 1));
      d   = 8'($urandom);
      st  = ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b11;
      send_frame(sel, d, 1'($urandom_range(0, 1)), st);
      drive(sel, 1'b1, int'($urandom_range(16, 100)));
    end
    rand_mode = 1'b0;
    wait_empty(0);
    wait_empty(1);
    check("ovr_total_a", ovr_cnt_a, exp_ovr_a);
    check("ovr_total_b", ovr_cnt_b, exp_ovr_b);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
